sram_1rw_req_ctrl: RTL
======================

Name: sram_1rw_req_ctrl

Overview:
Requester/controller that drives a single-port 1RW masked SRAM macro: BITS wide, WORD_DEPTH deep, one-cycle read latency, bitwise write mask.
Converts a valid/ready request channel into SRAM ce/we/addr/wd/w_mask strobes, captures read data into a response buffer with backpressure, and zero-initialises the array after reset.
Sits between core-side logic and the SRAM macro instance.

Parameters:
BITS, 2848, data and mask width
WORD_DEPTH, 32, number of SRAM words
ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= WORD_DEPTH
RSP_DEPTH, 2, response buffer entries; minimum 2
INIT_ON_RESET, 1, 1 = zero-fill the array after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  BITS  write data
req_wmask  in  BITS  bit i written iff mask[i]=1
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  BITS  read data, in request order
init_done  out  1  high once the array is initialised
addr_err  out  1  one-cycle pulse: accepted request had addr >= WORD_DEPTH
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wd  out  BITS  SRAM write data
sram_w_mask  out  BITS  SRAM write mask
sram_rd  in  BITS  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values: req_ready=0, rsp_valid=0, init_done=0, addr_err=0, sram_ce=0, sram_we=0, rsp_rdata=0. Response buffer is flushed and the in-flight flag is cleared.
- State machine has two states, INIT and RUN.
- Reset enters INIT if INIT_ON_RESET=1; otherwise it enters RUN with init_done=1 on the first cycle after reset.
- INIT, one word per cycle: sram_ce=1, sram_we=1, sram_wd=0, sram_w_mask=all-ones, sram_addr=counter 0..WORD_DEPTH-1, req_ready=0.
- INIT exits after address WORD_DEPTH-1 is written, which takes exactly WORD_DEPTH cycles. On the next cycle the block enters RUN and init_done=1; init_done stays high until reset.
- outstanding = buffer occupancy + in-flight read (0/1). pop = rsp_valid&rsp_ready.
- RUN: req_ready = (outstanding < RSP_DEPTH) || pop. req_ready is independent of req_we.
- Accept = req_valid&req_ready. SRAM strobes are combinational in the accept cycle:
  - sram_ce = accept && addr<WORD_DEPTH
  - sram_we = req_we
  - sram_addr, sram_wd and sram_w_mask pass through from the request
- When no request is accepted: sram_ce=0, sram_we=0, other SRAM outputs hold 0.
- Read accepted at cycle T: in-flight flag set for T+1. sram_rd is sampled at T+1 and pushed into the buffer, so rsp_valid is high at T+2 at the earliest.
- Responses are strictly in order. A push and a pop in the same cycle are both legal.
- rsp_rdata and rsp_valid hold stable while rsp_valid && !rsp_ready.
- Sustained throughput is one read per cycle when rsp_ready=1 continuously.
- Writes never consume buffer space and produce no response; write latency is 0 (strobe in the accept cycle).
- Out-of-range address (addr >= WORD_DEPTH):
  - request is still accepted; sram_ce=0
  - addr_err pulses at T+1
  - a read still produces one response with rdata=0, buffered at T+1, to preserve ordering
- Read-after-write to the same address in consecutive cycles returns the new data; the macro itself guarantees this.
- Reset mid-operation drops all in-flight and buffered responses and re-enters INIT. No response from before reset is ever presented afterwards.
- Never drive sram_ce with X: in RUN, gate it with req_valid.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state typedef (INIT, RUN)
  - helper function clog2
  - RSP_DEPTH minimum constant
- One natural sub-module: sram_rsp_fifo, a parameterised BITS x RSP_DEPTH synchronous FIFO with push, pop, count, full and empty.
- FSM, credit logic and SRAM strobe muxing stay in the top module.

Test Plan:
- Reset with INIT_ON_RESET=1 -> exactly 32 cycles of ce=1/we=1/wd=0/mask=all-ones at addresses 0..31; init_done rises on cycle 33; a subsequent read of addr 7 returns 0.
- Write addr 5, data 0xA5A5..., mask all-ones; then write addr 5, data all-ones, mask lower 16 bits; then read addr 5 -> rsp_rdata = 0xA5A5... with the lower 16 bits = 0xFFFF; rsp_valid two cycles after the read accept.
- Back-to-back reads of addrs 0..31 with rsp_ready=1 -> req_ready never drops; 32 in-order responses on consecutive cycles.
- Reads with rsp_ready=0 -> req_ready falls after 2 accepted reads; writes are also blocked. Raise rsp_ready -> responses are presented in order with data unchanged while stalled.
- Read at addr 31 (in range) then a configuration with WORD_DEPTH=20 and a read at addr 25 -> sram_ce=0, addr_err pulse, response rdata=0 in order.
- Assert rst with 2 buffered responses and 1 in flight -> rsp_valid=0 next cycle; INIT reruns; no stale response appears.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared state type, sizing helper and constants for the 1RW SRAM request controller.
package sram_ctrl_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } ctrl_state_e;

  // Fewer entries than this cannot sustain one read per cycle.
  localparam int unsigned RspDepthMin = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; rdata always shows the head entry so it can drive the
// response channel directly.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Data storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Valid/ready front end for a 1RW masked SRAM macro: strobe generation, in-order read
// responses with backpressure, and zero-fill of the array after reset.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BITS          = 2848,
  parameter int unsigned WORD_DEPTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned RSP_DEPTH     = 2,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  init_done,
  output logic                  addr_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_w_mask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int unsigned RspDepth = (RSP_DEPTH < RspDepthMin) ? RspDepthMin : RSP_DEPTH;
  localparam int unsigned CntW     = clog2(RspDepth + 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(WORD_DEPTH - 1);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q;
  logic                  inflight_q, inflight_oor_q;
  logic                  addr_err_q;

  logic [BITS-1:0]       fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  pop, accept, in_range, credit_ok;

  assign in_range  = (32'(req_addr) < WORD_DEPTH);
  assign rsp_valid = !rst && !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  // Every accepted read reserves a slot, so the buffer can never overflow.
  assign credit_ok = !fifo_full && ((32'(fifo_count) + 32'(inflight_q)) < RspDepth);
  assign req_ready = !rst && (state_q == StRun) && (credit_ok || pop);
  assign accept    = req_valid && req_ready;
  assign rsp_rdata = rsp_valid ? fifo_rdata : '0;
  assign init_done = init_done_q;
  assign addr_err  = addr_err_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wd     = '0;
    sram_w_mask = '0;
    if (!rst) begin
      unique case (state_q)
        StInit: begin
          sram_ce     = 1'b1;
          sram_we     = 1'b1;
          sram_addr   = init_cnt_q;
          sram_w_mask = '1;
          if (init_cnt_q == LastAddr) begin
            state_d    = StRun;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          end
        end
        StRun: begin
          if (accept) begin
            sram_ce     = in_range;
            sram_we     = req_we;
            sram_addr   = req_addr;
            sram_wd     = req_wdata;
            sram_w_mask = req_wmask;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= (INIT_ON_RESET != 0) ? StInit : StRun;
      init_cnt_q     <= '0;
      init_done_q    <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_oor_q <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      init_done_q    <= init_done_q || (state_d == StRun);
      inflight_q     <= accept && !req_we;
      inflight_oor_q <= accept && !req_we && !in_range;
      addr_err_q     <= accept && !in_range;
    end
  end

  // Out-of-range reads still occupy a slot and return zero to keep ordering.
  sram_rsp_fifo #(
    .WIDTH (BITS),
    .DEPTH (RspDepth),
    .CNT_W (CntW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata (inflight_oor_q ? '0 : sram_rd),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
